// File: rtl/vx_fpu_fma_arbiter.sv
// Round-robin arbiter sharing one FMA pipeline among NUM_REQS ports, with grant lock,
// credit limit and tag-routed responses. Optional perf counters: FPU_FMA_ARB_PERF_EN.
module vx_fpu_fma_arbiter #(
    parameter int NUM_REQS      = 4,
    parameter int NUM_LANES     = 4,
    parameter int TAG_WIDTH     = 4,
    parameter int MAX_PENDING   = 8,
    parameter int INST_FRM_BITS = 3,
    parameter int FP_FLAGS_BITS = 5,
    localparam int REQ_SEL_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int FMA_TAG_W    = REQ_SEL_W + TAG_WIDTH,
    localparam int PEND_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_REQS-1:0]                           req_valid,
    output logic [NUM_REQS-1:0]                           req_ready,
    input  logic [NUM_REQS-1:0]                           req_is_madd,
    input  logic [NUM_REQS-1:0]                           req_is_sub,
    input  logic [NUM_REQS-1:0]                           req_is_neg,
    input  logic [NUM_REQS-1:0][INST_FRM_BITS-1:0]        req_frm,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0]            req_mask,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][31:0]      req_dataa,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][31:0]      req_datab,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][31:0]      req_datac,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]            req_tag,
    output logic                                          fma_valid_in,
    input  logic                                          fma_ready_in,
    output logic                                          fma_is_madd,
    output logic                                          fma_is_sub,
    output logic                                          fma_is_neg,
    output logic [INST_FRM_BITS-1:0]                      fma_frm,
    output logic [NUM_LANES-1:0]                          fma_mask,
    output logic [NUM_LANES-1:0][31:0]                    fma_dataa,
    output logic [NUM_LANES-1:0][31:0]                    fma_datab,
    output logic [NUM_LANES-1:0][31:0]                    fma_datac,
    output logic [FMA_TAG_W-1:0]                          fma_tag_in,
    input  logic                                          fma_valid_out,
    output logic                                          fma_ready_out,
    input  logic [NUM_LANES-1:0][31:0]                    fma_result,
    input  logic                                          fma_has_fflags,
    input  logic [FP_FLAGS_BITS-1:0]                      fma_fflags,
    input  logic [FMA_TAG_W-1:0]                          fma_tag_out,
    output logic [NUM_REQS-1:0]                           rsp_valid,
    input  logic [NUM_REQS-1:0]                           rsp_ready,
    output logic [NUM_LANES-1:0][31:0]                    rsp_result,
    output logic                                          rsp_has_fflags,
    output logic [FP_FLAGS_BITS-1:0]                      rsp_fflags,
    output logic [TAG_WIDTH-1:0]                          rsp_tag
`ifdef FPU_FMA_ARB_PERF_EN
    ,
    output logic [31:0]                                   perf_credit_stalls,
    output logic [31:0]                                   perf_conflicts
`endif
);

    logic [REQ_SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_SEL_W-1:0] lock_idx_q, lock_idx_d;
    logic                 locked_q, locked_d;
    logic [PEND_W-1:0]    pending_q, pending_d;

    logic [REQ_SEL_W-1:0] grant_idx;
    logic [REQ_SEL_W-1:0] rsp_idx;
    logic                 credit_ok;
    logic                 any_valid;
    logic                 req_fire;
    logic                 rsp_fire;

    assign credit_ok    = (pending_q < PEND_W'(MAX_PENDING));
    assign any_valid    = |req_valid;
    assign fma_valid_in = reset & any_valid & credit_ok;
    assign req_fire     = fma_valid_in & fma_ready_in;

    // Locked grant holds the stalled port; otherwise scan upward from the last winner.
    always_comb begin
        int   scan;
        logic found;
        grant_idx = '0;
        found     = 1'b0;
        scan      = 0;
        if (locked_q) begin
            grant_idx = lock_idx_q;
        end else begin
            for (int i = 1; i <= NUM_REQS; i++) begin
                scan = (int'(rr_ptr_q) + i) % NUM_REQS;
                if (!found && req_valid[REQ_SEL_W'(scan)]) begin
                    found     = 1'b1;
                    grant_idx = REQ_SEL_W'(scan);
                end
            end
        end
    end

    assign fma_is_madd = req_is_madd[grant_idx];
    assign fma_is_sub  = req_is_sub[grant_idx];
    assign fma_is_neg  = req_is_neg[grant_idx];
    assign fma_frm     = req_frm[grant_idx];
    assign fma_mask    = req_mask[grant_idx];
    assign fma_dataa   = req_dataa[grant_idx];
    assign fma_datab   = req_datab[grant_idx];
    assign fma_datac   = req_datac[grant_idx];
    assign fma_tag_in  = {grant_idx, req_tag[grant_idx]};

    assign rsp_idx        = fma_tag_out[TAG_WIDTH +: REQ_SEL_W];
    assign fma_ready_out  = reset & rsp_ready[rsp_idx];
    assign rsp_fire       = fma_valid_out & fma_ready_out;
    assign rsp_result     = fma_result;
    assign rsp_has_fflags = fma_has_fflags;
    assign rsp_fflags     = fma_fflags;
    assign rsp_tag        = fma_tag_out[TAG_WIDTH-1:0];

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_port
        assign req_ready[gi] = reset & credit_ok & fma_ready_in & (grant_idx == REQ_SEL_W'(gi));
        assign rsp_valid[gi] = reset & fma_valid_out & (rsp_idx == REQ_SEL_W'(gi));
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        pending_d  = pending_q;
        if (req_fire) begin
            rr_ptr_d = grant_idx;
            locked_d = 1'b0;
        end else if (fma_valid_in && !fma_ready_in && !locked_q) begin
            locked_d   = 1'b1;
            lock_idx_d = grant_idx;
        end
        if (req_fire && !rsp_fire) begin
            pending_d = pending_q + PEND_W'(1);
        end else if (!req_fire && rsp_fire) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q   <= REQ_SEL_W'(NUM_REQS - 1);
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            pending_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            pending_q  <= pending_d;
        end
    end

`ifdef FPU_FMA_ARB_PERF_EN
    logic [31:0] perf_credit_stalls_q, perf_credit_stalls_d;
    logic [31:0] perf_conflicts_q, perf_conflicts_d;

    always_comb begin
        perf_credit_stalls_d = perf_credit_stalls_q + 32'(any_valid & ~credit_ok);
        perf_conflicts_d     = perf_conflicts_q + 32'($countones(req_valid) > 1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_credit_stalls_q <= '0;
            perf_conflicts_q     <= '0;
        end else begin
            perf_credit_stalls_q <= perf_credit_stalls_d;
            perf_conflicts_q     <= perf_conflicts_d;
        end
    end

    assign perf_credit_stalls = perf_credit_stalls_q;
    assign perf_conflicts     = perf_conflicts_q;
`endif

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(req_fire && !rsp_fire && pending_q == PEND_W'(MAX_PENDING)))
                else $error("fma arbiter: pending overflow");
            assert (!(rsp_fire && !req_fire && pending_q == '0))
                else $error("fma arbiter: pending underflow");
            assert (!fma_valid_out || int'(rsp_idx) < NUM_REQS)
                else $error("fma arbiter: response index out of range");
        end
    end
`endif

endmodule

// File: tb/tb_vx_fpu_fma_arbiter.sv
// Randomized and directed bench for vx_fpu_fma_arbiter against a queue-based reference model.
module tb_vx_fpu_fma_arbiter;
    localparam int N  = 4;
    localparam int L  = 4;
    localparam int TW = 4;
    localparam int MP = 8;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]              req_valid, req_ready, req_is_madd, req_is_sub, req_is_neg;
    logic [N-1:0][2:0]         req_frm;
    logic [N-1:0][L-1:0]       req_mask;
    logic [N-1:0][L-1:0][31:0] req_dataa, req_datab, req_datac;
    logic [N-1:0][TW-1:0]      req_tag;
    logic                      fma_valid_in, fma_ready_in, fma_is_madd, fma_is_sub, fma_is_neg;
    logic [2:0]                fma_frm;
    logic [L-1:0]              fma_mask;
    logic [L-1:0][31:0]        fma_dataa, fma_datab, fma_datac, fma_result, rsp_result;
    logic [5:0]                fma_tag_in, fma_tag_out;
    logic                      fma_valid_out, fma_ready_out, fma_has_fflags, rsp_has_fflags;
    logic [4:0]                fma_fflags, rsp_fflags;
    logic [N-1:0]              rsp_valid, rsp_ready;
    logic [TW-1:0]             rsp_tag;
`ifdef FPU_FMA_ARB_PERF_EN
    logic [31:0]               perf_credit_stalls, perf_conflicts;
`endif

    vx_fpu_fma_arbiter #(.NUM_REQS(N), .NUM_LANES(L), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_madd(req_is_madd),
        .req_is_sub(req_is_sub), .req_is_neg(req_is_neg), .req_frm(req_frm), .req_mask(req_mask),
        .req_dataa(req_dataa), .req_datab(req_datab), .req_datac(req_datac), .req_tag(req_tag),
        .fma_valid_in(fma_valid_in), .fma_ready_in(fma_ready_in), .fma_is_madd(fma_is_madd),
        .fma_is_sub(fma_is_sub), .fma_is_neg(fma_is_neg), .fma_frm(fma_frm), .fma_mask(fma_mask),
        .fma_dataa(fma_dataa), .fma_datab(fma_datab), .fma_datac(fma_datac), .fma_tag_in(fma_tag_in),
        .fma_valid_out(fma_valid_out), .fma_ready_out(fma_ready_out), .fma_result(fma_result),
        .fma_has_fflags(fma_has_fflags), .fma_fflags(fma_fflags), .fma_tag_out(fma_tag_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_has_fflags(rsp_has_fflags), .rsp_fflags(rsp_fflags), .rsp_tag(rsp_tag)
`ifdef FPU_FMA_ARB_PERF_EN
        , .perf_credit_stalls(perf_credit_stalls), .perf_conflicts(perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;
        logic [TW-1:0] tag;
        logic [127:0] res;
    } op_t;

    op_t     inflight[$];
    int      last_win, lock_port;
    bit      lock_on;
    bit      req_fired;
    int      fired_port;
    int      checks   = 0;
    int      failures = 0;
    bit      busy[N];

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    function automatic int first_after(input int last, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    task automatic new_req(input int p);
        req_dataa[p]   = {$urandom, $urandom, $urandom, $urandom};
        req_datab[p]   = {$urandom, $urandom, $urandom, $urandom};
        req_datac[p]   = {$urandom, $urandom, $urandom, $urandom};
        req_tag[p]     = 4'($urandom);
        req_frm[p]     = 3'($urandom);
        req_mask[p]    = 4'($urandom);
        req_is_madd[p] = 1'($urandom);
        req_is_sub[p]  = 1'($urandom);
        req_is_neg[p]  = 1'($urandom);
    endtask

    task automatic drive_fma_out(input bit en);
        if (en && inflight.size() > 0) begin
            fma_valid_out = 1'b1;
            fma_tag_out   = {2'(inflight[0].port), inflight[0].tag};
            fma_result    = inflight[0].res;
        end else begin
            fma_valid_out = 1'b0;
            fma_tag_out   = 6'($urandom);
            fma_result    = {$urandom, $urandom, $urandom, $urandom};
        end
        fma_has_fflags = 1'($urandom);
        fma_fflags     = 5'($urandom);
    endtask

    // Settle, compare every output with the model, then advance the model by one cycle.
    task automatic step();
        bit any, cred, ev, rf, sf;
        int g, ri;
        op_t op;
        #1;
        req_fired = 1'b0;
        if (!reset) begin
            check_val("rst_req_ready", req_ready, 0);
            check_val("rst_rsp_valid", rsp_valid, 0);
            check_val("rst_fma_valid_in", fma_valid_in, 0);
            check_val("rst_fma_ready_out", fma_ready_out, 0);
            inflight.delete();
            last_win = N - 1;
            lock_on  = 1'b0;
            return;
        end
        any  = |req_valid;
        cred = inflight.size() < MP;
        ev   = any && cred;
        g    = lock_on ? lock_port : first_after(last_win, req_valid);
        check_val("fma_valid_in", fma_valid_in, ev);
        if (any) check_val("req_ready", req_ready, (fma_ready_in && cred) ? (4'b1 << g) : 4'b0);
        if (ev) begin
            check_val("fma_tag_in", fma_tag_in, {2'(g), req_tag[g]});
            check_val("fma_dataa", fma_dataa, req_dataa[g]);
            check_val("fma_datab", fma_datab, req_datab[g]);
            check_val("fma_datac", fma_datac, req_datac[g]);
            check_val("fma_ctrl", {fma_is_madd, fma_is_sub, fma_is_neg, fma_frm, fma_mask},
                      {req_is_madd[g], req_is_sub[g], req_is_neg[g], req_frm[g], req_mask[g]});
        end
        sf = 1'b0;
        if (fma_valid_out) begin
            ri = inflight[0].port;
            check_val("rsp_valid", rsp_valid, 4'b1 << ri);
            check_val("fma_ready_out", fma_ready_out, rsp_ready[ri]);
            check_val("rsp_tag", rsp_tag, inflight[0].tag);
            check_val("rsp_result", rsp_result, inflight[0].res);
            check_val("rsp_fflags", {rsp_has_fflags, rsp_fflags}, {fma_has_fflags, fma_fflags});
            sf = rsp_ready[ri];
        end else begin
            check_val("rsp_valid_idle", rsp_valid, 0);
        end
        rf = ev && fma_ready_in;
        if (sf) void'(inflight.pop_front());
        if (rf) begin
            op.port = g;
            op.tag  = req_tag[g];
            op.res  = {$urandom, $urandom, $urandom, $urandom};
            inflight.push_back(op);
            last_win   = g;
            lock_on    = 1'b0;
            req_fired  = 1'b1;
            fired_port = g;
        end else if (ev && !fma_ready_in && !lock_on) begin
            lock_on   = 1'b1;
            lock_port = g;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '1;
        fma_ready_in = 1'b1;
        rsp_ready = '1;
        drive_fma_out(1'b0);
        step();
        @(negedge clk);
        step();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int fires;
        logic [127:0] saved;
        for (int p = 0; p < N; p++) begin
            new_req(p);
            busy[p] = 1'b0;
        end
        reset = 1'b0;
        last_win = N - 1;
        lock_port = 0;
        lock_on = 1'b0;
        @(negedge clk);
        do_reset();

        // Round-robin order from reset with all ports valid.
        req_valid = '1; fma_ready_in = 1'b1; drive_fma_out(1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("rr_order", fma_tag_in[5:4], k % N);
            @(negedge clk);
        end

        // Lock on port 2, then reset mid-operation with 5 in flight.
        req_valid = 4'b0100; fma_ready_in = 1'b0;
        step();
        check_val("lock_pre_rst", fma_valid_in, 1);
        @(negedge clk);
        reset = 1'b0;
        step();
        @(negedge clk);
        reset = 1'b1; req_valid = '1; fma_ready_in = 1'b1;
        step();
        check_val("post_rst_port0", fma_tag_in[5:4], 0);
        fires = req_fired;

        // Credit limit: exactly MAX_PENDING accepts with no responses.
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            drive_fma_out(1'b0);
            step();
            fires += req_fired;
        end
        check_val("credit_fires", fires, MP);
        check_val("credit_block", fma_valid_in, 0);

        // One response frees exactly one credit.
        fires = 0;
        @(negedge clk); drive_fma_out(1'b1); step(); fires += req_fired;
        @(negedge clk); drive_fma_out(1'b0); step(); fires += req_fired;
        @(negedge clk); drive_fma_out(1'b0); step(); fires += req_fired;
        check_val("release_one", fires, 1);

        // Response frees a credit, then simultaneous req and rsp fire keeps the count.
        @(negedge clk); drive_fma_out(1'b1); step();
        @(negedge clk); drive_fma_out(1'b1); step();
        check_val("both_fire_req", req_fired, 1);
        @(negedge clk); drive_fma_out(1'b0); step();
        check_val("both_fire_credit", fma_valid_in, 1);
        @(negedge clk); drive_fma_out(1'b0); step();
        check_val("both_fire_full", fma_valid_in, 0);

        // Grant lock under backpressure.
        @(negedge clk);
        do_reset();
        new_req(2); saved = req_dataa[2];
        req_valid = 4'b0100; fma_ready_in = 1'b0; drive_fma_out(1'b0);
        for (int k = 1; k <= 3; k++) begin
            if (k == 2) req_valid = 4'b0101;
            step();
            check_val("lock_grant", fma_tag_in[5:4], 2);
            check_val("lock_dataa", fma_dataa, saved);
            @(negedge clk);
        end
        fma_ready_in = 1'b1;
        step();
        check_val("lock_fire2", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        step();
        check_val("lock_fire0", req_ready, 4'b0001);

        // Response routing by tag index.
        @(negedge clk);
        do_reset();
        req_tag[3] = 4'hA; req_valid = 4'b1000; fma_ready_in = 1'b1; drive_fma_out(1'b0);
        step();
        @(negedge clk);
        req_valid = '0; rsp_ready = 4'b0111; drive_fma_out(1'b1);
        step();
        check_val("rsp_route_valid", rsp_valid, 4'b1000);
        check_val("rsp_route_hold", fma_ready_out, 0);
        @(negedge clk);
        rsp_ready = '1; drive_fma_out(1'b1);
        step();
        check_val("rsp_route_tag", rsp_tag, 4'hA);
        check_val("rsp_route_ready", fma_ready_out, 1);

        // Randomized traffic with held requests and random backpressure.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                if (!busy[p] && ($urandom % 3 == 0)) begin
                    busy[p] = 1'b1;
                    new_req(p);
                end
                req_valid[p] = busy[p];
            end
            fma_ready_in = ($urandom % 4) != 0;
            rsp_ready    = 4'($urandom);
            drive_fma_out(1'($urandom));
            step();
            if (req_fired) busy[fired_port] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
